// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and compare helper for the PWM output stage
package pwm_pkg;

    localparam int          PWM_BITS             = 8;
    localparam int          PWM_STEPS            = 256;
    localparam logic [7:0]  DUTY_FULL            = 8'hFF;
    localparam int          PWM_PRESCALE_DEFAULT = 13;

    // Full-scale duty is forced high so the top code yields a true 100 % level.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                       input logic [PWM_BITS-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler and 8-bit PWM step counter with period boundary strobe
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE_DEFAULT,
    parameter int PRESC_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] cnt,
    output logic                step,
    output logic                period_end
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0]  r_presc;
    logic [PWM_BITS-1:0] r_cnt;
    logic                w_step;

    assign w_step     = (r_presc == PRESC_LAST);
    assign step       = w_step;
    assign cnt        = r_cnt;
    assign period_end = w_step && (r_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else begin
            r_presc <= w_step ? '0 : r_presc + 1'b1;
            if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - drives 16 pins low, high or with a shared glitch-free PWM waveform
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE_DEFAULT,
    parameter int PRESC_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out
);

    logic [PWM_BITS-1:0] w_cnt;
    logic                w_step;
    logic                w_period_end;
    logic                w_load_duty;
    logic                w_pwm;
    logic [15:0]         w_en_out;
    logic [15:0]         w_en_pwm;
    logic [15:0]         w_next_out;
    logic [PWM_BITS-1:0] r_duty_q;
    logic [15:0]         r_out;

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PRESC_W  (PRESC_W)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt        (w_cnt),
        .step       (w_step),
        .period_end (w_period_end)
    );

    // Shadow duty only moves on the last step of a period so the waveform never glitches.
    assign w_load_duty = w_step && w_period_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_q <= '0;
        end else if (w_load_duty) begin
            r_duty_q <= pwm_duty_cycle;
        end
    end

    assign w_pwm      = pwm_level(w_cnt, r_duty_q);
    assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_next_out = w_en_out & (~w_en_pwm | {16{w_pwm}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_next_out;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - scoreboard bench for pwm_peripheral
module tb_pwm_peripheral;

    localparam int PERIOD     = 3328;
    localparam int LAST_DRIVE = PERIOD - 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string name;
        int    high;
        int    falls;
        int    first;
    } exp_t;
    exp_t sb[$];

    pwm_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    task automatic push_exp(input string name, input int high, input int falls, input int first);
        exp_t e;
        e.name = name; e.high = high; e.falls = falls; e.first = first;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: out=%h expected 0000", out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_held: out=%h expected 0000", out);
            end
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Observes one PWM period on a pin; optionally drives a duty change after sample chg_at.
    task automatic measure(input int pin, input int chg_at, input logic [7:0] chg_duty,
                           output int high, output int falls, output int first,
                           output int others, output int start_cyc);
        logic [15:0] mask;
        logic        prv, cur;
        mask = 16'h0001 << pin;
        high = 0; falls = 0; first = -1; others = 0; start_cyc = cyc;
        prv = out[pin];
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            cur = out[pin];
            if (cur) high++;
            if (prv && !cur) falls++;
            if (cur && first < 0) first = i;
            if ((out & ~mask) != 16'h0000) others++;
            prv = cur;
            if (i == chg_at) pwm_duty_cycle = chg_duty;
        end
    endtask

    task automatic test_reset;
        int h, f, fi, o, s;
        exp_t e;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h80;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            push_exp($sformatf("all_off_p%0d", w), 0, 0, -1);
            measure(0, -1, 8'h00, h, f, fi, o, s);
            e = sb.pop_front();
            checks++;
            if (h !== e.high || o !== 0) begin
                errors++;
                $display("FAIL %s: pin0_high=%0d others=%0d expected %0d and 0", e.name, h, o, e.high);
            end
        end
    endtask

    task automatic test_enable_static;
        set_en(16'hFFFF, 16'h0000);
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL en_no_zero_latency: out=%h expected 0000", out);
        end
        tick();
        checks++;
        if (out !== 16'hFFFF) begin
            errors++;
            $display("FAIL en_static_high: out=%h expected ffff", out);
        end
        set_en(16'h00F0, 16'h0000);
        tick();
        checks++;
        if (out !== 16'h00F0) begin
            errors++;
            $display("FAIL en_mid_period: out=%h expected 00f0", out);
        end
    endtask

    task automatic test_pwm_pin0;
        int h, f, fi, o, s;
        int rise [3];
        exp_t e;
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        do_reset();
        push_exp("pin0_p0", 0, 0, -1);
        push_exp("pin0_p1", 1664, 1, 0);
        push_exp("pin0_p2", 1664, 1, 0);
        for (int w = 0; w < 3; w++) begin
            measure(0, -1, 8'h00, h, f, fi, o, s);
            rise[w] = s + fi + 1;
            e = sb.pop_front();
            checks++;
            if (h !== e.high || f !== e.falls || fi !== e.first || o !== 0) begin
                errors++;
                $display("FAIL %s: high=%0d falls=%0d first=%0d others=%0d expected %0d %0d %0d 0",
                         e.name, h, f, fi, o, e.high, e.falls, e.first);
            end
        end
        checks++;
        if (rise[2] - rise[1] !== PERIOD) begin
            errors++;
            $display("FAIL pin0_period: got %0d expected %0d", rise[2] - rise[1], PERIOD);
        end
    endtask

    task automatic test_duty_sweep;
        int h, f, fi, o, s;
        exp_t e;
        int         exp_high [7] = '{0, 13, 3302, 3328, 0, 832, 2496};
        int         exp_fall [7] = '{0, 1, 1, 0, 1, 1, 1};
        int         exp_frst [7] = '{-1, 0, 0, 0, -1, 0, 0};
        int         chg_at   [7] = '{-1, LAST_DRIVE, LAST_DRIVE, LAST_DRIVE, LAST_DRIVE, 1663, -1};
        logic [7:0] chg_duty [7] = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h40, 8'hC0, 8'h00};
        set_en(16'h8000, 16'h8000);
        pwm_duty_cycle = 8'h01;
        do_reset();
        for (int w = 0; w < 7; w++) begin
            push_exp($sformatf("sweep_p%0d", w), exp_high[w], exp_fall[w], exp_frst[w]);
            measure(15, chg_at[w], chg_duty[w], h, f, fi, o, s);
            e = sb.pop_front();
            checks++;
            if (h !== e.high || f !== e.falls || fi !== e.first || o !== 0) begin
                errors++;
                $display("FAIL %s: high=%0d falls=%0d first=%0d others=%0d expected %0d %0d %0d 0",
                         e.name, h, f, fi, o, e.high, e.falls, e.first);
            end
        end
    endtask

    task automatic test_reset_mid;
        int h, f, fi, o, s;
        exp_t e;
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        for (int i = 0; i < PERIOD + 100; i++) tick();
        checks++;
        if (out !== 16'h0001) begin
            errors++;
            $display("FAIL mid_before_reset: out=%h expected 0001", out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_async_clear: out=%h expected 0000", out);
        end
        do_reset();
        push_exp("rst_p0", 0, 0, -1);
        push_exp("rst_p1", 1664, 1, 0);
        push_exp("rst_p2", 1664, 1, 0);
        for (int w = 0; w < 3; w++) begin
            measure(0, -1, 8'h00, h, f, fi, o, s);
            e = sb.pop_front();
            checks++;
            if (h !== e.high || f !== e.falls || fi !== e.first || o !== 0) begin
                errors++;
                $display("FAIL %s: high=%0d falls=%0d first=%0d others=%0d expected %0d %0d %0d 0",
                         e.name, h, f, fi, o, e.high, e.falls, e.first);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h00;
        tick();
        tick();
        test_reset();
        test_enable_static();
        test_pwm_pin0();
        test_duty_sweep();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Output stage that consumes the five control registers written over SPI and drives the 16 user output pins. Each pin is forced low, forced high, or driven with a shared PWM waveform, selected by its output-enable and PWM-enable bits. Duty-cycle updates are double-buffered and take effect only at a PWM period boundary, so the waveform never glitches.

## Interface
- PRESCALE, 13: clk cycles per PWM step, minimum 1. The period is 256 × PRESCALE clk, about 3.0 kHz at 10 MHz.
- PRESC_W, 8: prescaler counter width. Must satisfy 2^PRESC_W ≥ PRESCALE.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en_reg_out_7_0  in  8  output enable, pins 7:0. 1 = pin driven, 0 = pin low.
- en_reg_out_15_8  in  8  output enable, pins 15:8.
- en_reg_pwm_7_0  in  8  PWM select, pins 7:0. 1 = PWM waveform, 0 = static high.
- en_reg_pwm_15_8  in  8  PWM select, pins 15:8.
- pwm_duty_cycle  in  8  requested duty, in units of 1/256. 0xFF means 100 %.
- out  out  16  registered pin drive.

## Operation
- All inputs are synchronous to clk and are used directly, with no resynchronisation.
- Prescaler `presc`:
  - counts 0 … PRESCALE−1, then wraps to 0.
  - `step` = (presc == PRESCALE−1).
- PWM counter `cnt` (8 bit):
  - increments on `step`, wrapping 255 → 0.
  - `period_end` = step && cnt == 255.
- Duty shadow `duty_q` (8 bit):
  - loads pwm_duty_cycle on `period_end` only.
  - Any other change on pwm_duty_cycle is ignored until the next boundary.
- PWM waveform `pwm`:
  - 1 if duty_q == 0xFF.
  - otherwise (cnt < duty_q).
  - As a result, duty 0x00 gives a constant 0 and duty 0xFF gives a constant 1.
- Pin i, where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - next_out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
  - out ← next_out every clk.
- Enable registers are not buffered. A change is visible on out one clk later, including mid-period.
- Reset values: presc = 0, cnt = 0, duty_q = 0x00, out = 16'h0000.
  - All pins are low while rst_n = 0.
  - Assertion clears everything immediately, including mid-period.
  - After release, counting restarts from presc = 0, cnt = 0.

## Timing
- Enable-to-pin latency is exactly 1 clk.
- Duty-to-waveform latency:
  - The new duty is used from the first clk of the next period.
  - The worst case is 256 × PRESCALE clk.
- Period boundaries fall at clk indices k × 256 × PRESCALE after reset release (k ≥ 1). The counter side of the pipeline has no latency.
- High time per period:
  - duty_q × PRESCALE clk for duty_q < 0xFF.
  - the full period for 0xFF.
  - The rising edge is at period start, shifted by the 1-clk output register.
- First period after reset: duty_q = 0, so PWM-selected pins stay low until the first `period_end` loads a duty.
- Simultaneous events:
  - A duty write in the same clk as `period_end` is captured, because the shadow samples the current input.
  - An enable change in the same clk uses the new enables on the next out update.

## Structure
- Shared package `pwm_pkg` holds:
  - PWM_BITS = 8 and PWM_STEPS = 256.
  - DUTY_FULL = 8'hFF.
  - PWM_PRESCALE_DEFAULT = 13.
- Sub-module `pwm_timebase` holds presc and cnt.
  - Outputs: cnt[7:0], step and period_end.
  - Parameter: PRESCALE.
- Top level holds duty_q, the compare logic and the output register.

## Test plan
- Reset, then all enables 0 and duty 0x80 for 2 periods → out == 0x0000 throughout. Also check out == 0 while rst_n is held low.
- en_out = 0xFFFF, en_pwm = 0x0000 → out == 0xFFFF exactly 1 clk after the enable write.
- en_out = 0x0001, en_pwm = 0x0001, duty 0x80, PRESCALE = 13 → pin 0:
  - from the second period on, high 1664 clk and low 1664 clk.
  - period 3328 clk.
  - other pins 0.
- Duty sweep on pin 15 → for each duty, check the full following period:
  - 0x00: never high.
  - 0x01: high 13 clk.
  - 0xFE: high 3302 clk.
  - 0xFF: high the full 3328 clk with no low pulse.
- Duty changed 0x40 → 0xC0 at mid-period → the current period completes with 832 clk high. The next period is 2496 clk high, with no glitch.
- rst_n pulsed low mid-period with duty 0x80 active:
  - out goes 0 asynchronously.
  - After release, the counter restarts and the pin stays low for one full period (duty_q = 0).
  - 50 % resumes from the second period.
